// File: rtl/ofdm_tx_input_buffer_param.sv
// OFDM Tx input buffer: AXI4-Lite sample pushes into a FIFO, streamed out on
// AXI4-Stream in programmable-length frames with TLAST on the last word.
module ofdm_tx_input_buffer_param #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int DEFAULT_FRAME_LEN  = 64
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int LvlW = PtrW + 1;
  localparam logic [15:0]     DefaultLen = 16'(DEFAULT_FRAME_LEN);
  localparam logic [LvlW-1:0] FullLevel  = LvlW'(FIFO_DEPTH);
  localparam logic [1:0]      RespOkay   = 2'b00;
  localparam logic [1:0]      RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    RegData     = 2'd0,
    RegCtrl     = 2'd1,
    RegFrameLen = 2'd2,
    RegStatus   = 2'd3
  } regSel_e;

  logic [C_AXIS_TDATA_WIDTH-1:0] fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtr, rdPtr;
  logic [LvlW-1:0] level;
  logic            ctrlEnable, flushPending, overflow;
  logic [15:0]     frameLenReg, activeLen, frameCnt;

  regSel_e wrSel, rdSel;
  logic    wrEn, rdEn, dataWr, ctrlWr, lenWr, statusWr;
  logic    fifoFull, fifoEmpty, beatHeld, handshake;
  logic    flushExec, loadBeat, pushOk, slvErr, boundary, nextTlast;
  logic [15:0] lenWrVal, frameLenNext, activeLenNext, cntAfter;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdValue;
  logic    unusedBits;

  assign wrSel    = regSel_e'(s_axi_awaddr[3:2]);
  assign rdSel    = regSel_e'(s_axi_araddr[3:2]);
  assign wrEn     = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign rdEn     = s_axi_arready && s_axi_arvalid;
  assign dataWr   = wrEn && (wrSel == RegData);
  assign ctrlWr   = wrEn && (wrSel == RegCtrl);
  assign lenWr    = wrEn && (wrSel == RegFrameLen);
  assign statusWr = wrEn && (wrSel == RegStatus);

  assign fifoFull  = (level == FullLevel);
  assign fifoEmpty = (level == '0);
  assign beatHeld  = m_axis_tvalid && !m_axis_tready;
  assign handshake = m_axis_tvalid && m_axis_tready;

  // A flush waits behind a stalled beat so that beat is still delivered intact.
  assign flushExec = (flushPending || (ctrlWr && s_axi_wdata[1])) && !beatHeld;
  assign loadBeat  = !beatHeld && !flushExec && ctrlEnable && !fifoEmpty;
  assign pushOk    = dataWr && !fifoFull && !flushExec;
  assign slvErr    = dataWr && fifoFull && !flushExec;

  assign lenWrVal      = (s_axi_wdata[15:0] == 16'd0) ? 16'd1 : s_axi_wdata[15:0];
  assign frameLenNext  = lenWr ? lenWrVal : frameLenReg;
  // A new length is adopted only where no beat of the current frame is in flight.
  assign boundary      = (handshake && m_axis_tlast) || (frameCnt == 16'd0 && !m_axis_tvalid);
  assign activeLenNext = boundary ? frameLenNext : activeLen;
  assign cntAfter      = handshake ? (m_axis_tlast ? 16'd0 : frameCnt + 16'd1) : frameCnt;
  assign nextTlast     = (cntAfter == activeLenNext - 16'd1);

  assign s_axi_wready = s_axi_awready;
  assign s_axi_rresp  = RespOkay;
  assign unusedBits   = &{1'b0, s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    rdValue = '0;
    case (rdSel)
      RegCtrl:     rdValue = {31'b0, ctrlEnable};
      RegFrameLen: rdValue = {16'b0, frameLenReg};
      RegStatus:   rdValue = {13'b0, overflow, fifoFull, fifoEmpty, 16'(level)};
      default:     rdValue = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi_awready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RespOkay;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      ctrlEnable    <= 1'b0;
      flushPending  <= 1'b0;
      overflow      <= 1'b0;
      frameLenReg   <= DefaultLen;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      if (wrEn) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= slvErr ? RespSlvErr : RespOkay;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
      if (rdEn) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rdValue;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      if (ctrlWr) ctrlEnable <= s_axi_wdata[0];
      frameLenReg <= frameLenNext;

      if (slvErr)        overflow <= 1'b1;
      else if (statusWr) overflow <= 1'b0;

      if (flushExec)                       flushPending <= 1'b0;
      else if (ctrlWr && s_axi_wdata[1])   flushPending <= 1'b1;
    end
  end

  // NOTE: sample storage has no reset; validity is tracked by the pointers and level.
  always_ff @(posedge ACLK) begin
    if (pushOk) fifoMem[wrPtr] <= s_axi_wdata[C_AXIS_TDATA_WIDTH-1:0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      level         <= '0;
      frameCnt      <= 16'd0;
      activeLen     <= DefaultLen;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      activeLen <= activeLenNext;
      if (flushExec) begin
        wrPtr    <= '0;
        rdPtr    <= '0;
        level    <= '0;
        frameCnt <= 16'd0;
      end else begin
        if (pushOk)   wrPtr <= wrPtr + 1'b1;
        if (loadBeat) rdPtr <= rdPtr + 1'b1;
        level    <= level + LvlW'(pushOk) - LvlW'(loadBeat);
        frameCnt <= cntAfter;
      end

      if (loadBeat) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= fifoMem[rdPtr];
        m_axis_tlast  <= nextTlast;
      end else if (handshake) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_tx_input_buffer_param.sv
// Directed bench for ofdm_tx_input_buffer_param: register access, overflow,
// framing, stall stability, deferred flush, frame-length change and reset.
module tb_ofdm_tx_input_buffer_param;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TW = 32;

  logic          tb_ACLK = 1'b0;
  logic          tb_ARESETN;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]    s_axi_wstrb;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rvalid, s_axi_rready;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

  int vectors = 0;
  int miscompares = 0;

  ofdm_tx_input_buffer_param #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .C_AXIS_TDATA_WIDTH(TW),
    .FIFO_DEPTH(16), .DEFAULT_FRAME_LEN(64)
  ) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    do begin @(negedge tb_ACLK); n++; end while (!s_axi_awready && n < 20);
    if (!s_axi_awready) check("aw_timeout", 32'(s_axi_awready), 32'd1);
    @(negedge tb_ACLK);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge tb_ACLK); n++; end
    if (!s_axi_bvalid) check("b_timeout", 32'(s_axi_bvalid), 32'd1);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge tb_ACLK);
    s_axi_bready = 1'b0;
  endtask

  task automatic axiRead(input logic [3:0] addr, output logic [31:0] data);
    int n = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    do begin @(negedge tb_ACLK); n++; end while (!s_axi_arready && n < 20);
    if (!s_axi_arready) check("ar_timeout", 32'(s_axi_arready), 32'd1);
    @(negedge tb_ACLK);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge tb_ACLK); n++; end
    if (!s_axi_rvalid) check("r_timeout", 32'(s_axi_rvalid), 32'd1);
    data = s_axi_rdata;
    s_axi_rready = 1'b1;
    @(negedge tb_ACLK);
    s_axi_rready = 1'b0;
  endtask

  task automatic expectBeat(input string tag, input logic [31:0] data, input logic last);
    int n = 0;
    m_axis_tready = 1'b1;
    while (!m_axis_tvalid && n < 20) begin @(negedge tb_ACLK); n++; end
    check({tag, "_valid"}, 32'(m_axis_tvalid), 32'd1);
    check({tag, "_data"}, m_axis_tdata, data);
    check({tag, "_last"}, 32'(m_axis_tlast), 32'(last));
    @(negedge tb_ACLK);
  endtask

  logic [1:0]  resp;
  logic [31:0] rd, sData;
  logic        sLast, stalled;
  logic [15:0] pat;
  int          idx, cyc;

  initial begin
    tb_ARESETN = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; m_axis_tready = 1'b0;
    repeat (2) @(negedge tb_ACLK);
    check("rst_outs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                       s_axi_rvalid, m_axis_tvalid, m_axis_tlast, s_axi_bresp, s_axi_rresp}, 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    tb_ARESETN = 1'b1;
    @(negedge tb_ACLK);

    axiRead(4'h8, rd);  check("rst_framelen", rd, 32'd64);
    axiRead(4'hC, rd);  check("rst_status", rd, 32'h0001_0000);
    axiRead(4'h4, rd);  check("rst_ctrl", rd, 32'd0);

    // 1: eight words, frame length 4, continuous tready
    axiWrite(4'h8, 32'd4, resp);
    for (int i = 0; i < 8; i++) axiWrite(4'h0, 32'(32'h11 + i), resp);
    axiRead(4'h0, rd);  check("t1_data_read", rd, 32'd0);
    axiWrite(4'h4, 32'd1, resp);
    m_axis_tready = 1'b1;
    cyc = 0;
    while (!m_axis_tvalid && cyc < 20) begin @(negedge tb_ACLK); cyc++; end
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", 32'(m_axis_tvalid), 32'd1);
      check("t1_data", m_axis_tdata, 32'(32'h11 + i));
      check("t1_last", 32'(m_axis_tlast), 32'(i == 3 || i == 7));
      @(negedge tb_ACLK);
    end
    check("t1_drained", 32'(m_axis_tvalid), 32'd0);
    axiRead(4'hC, rd);  check("t1_status", rd, 32'h0001_0000);

    // 2: overflow on the 17th word, sticky flag cleared by a STATUS write
    axiWrite(4'h4, 32'd0, resp);
    for (int i = 0; i < 16; i++) axiWrite(4'h0, 32'(32'h200 + i), resp);
    check("t2_16th_resp", 32'(resp), 32'd0);
    axiWrite(4'h0, 32'h0000_0216, resp);
    check("t2_17th_resp", 32'(resp), 32'd2);
    axiRead(4'hC, rd);  check("t2_status_ovf", rd, 32'h0006_0010);
    axiWrite(4'hC, 32'd0, resp);
    check("t2_status_wr_resp", 32'(resp), 32'd0);
    axiRead(4'hC, rd);  check("t2_status_clr", rd, 32'h0002_0010);
    axiWrite(4'h4, 32'd2, resp);
    axiRead(4'hC, rd);  check("t2_flushed", rd, 32'h0001_0000);
    axiRead(4'h4, rd);  check("t2_ctrl_flush_reads0", rd, 32'd0);

    // 3: frame length 3, tready toggled in a fixed irregular pattern
    axiWrite(4'h8, 32'd3, resp);
    for (int i = 0; i < 6; i++) axiWrite(4'h0, 32'(32'h31 + i), resp);
    m_axis_tready = 1'b0;
    axiWrite(4'h4, 32'd1, resp);
    pat = 16'b1011_0010_1100_1001;
    idx = 0; cyc = 0; stalled = 1'b0; sData = '0; sLast = 1'b0;
    while (idx < 6 && cyc < 200) begin
      if (stalled) begin
        check("t3_stall_valid", 32'(m_axis_tvalid), 32'd1);
        check("t3_stall_data", m_axis_tdata, sData);
        check("t3_stall_last", 32'(m_axis_tlast), 32'(sLast));
      end
      m_axis_tready = pat[cyc % 16];
      if (m_axis_tvalid && m_axis_tready) begin
        check("t3_data", m_axis_tdata, 32'(32'h31 + idx));
        check("t3_last", 32'(m_axis_tlast), 32'(idx == 2 || idx == 5));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = m_axis_tvalid;
        sData = m_axis_tdata;
        sLast = m_axis_tlast;
      end
      @(negedge tb_ACLK);
      cyc++;
    end
    check("t3_beat_count", 32'(idx), 32'd6);

    // 4: flush requested while a beat is stalled
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) axiWrite(4'h0, 32'(32'h41 + i), resp);
    axiRead(4'hC, rd);  check("t4_level_held", rd, 32'h0000_0004);
    axiWrite(4'h4, 32'd3, resp);
    check("t4_pending_valid", 32'(m_axis_tvalid), 32'd1);
    check("t4_pending_data", m_axis_tdata, 32'h41);
    expectBeat("t4_pending", 32'h41, 1'b0);
    check("t4_after_flush_valid", 32'(m_axis_tvalid), 32'd0);
    axiRead(4'hC, rd);  check("t4_status", rd, 32'h0001_0000);
    axiRead(4'h4, rd);  check("t4_ctrl", rd, 32'd1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) axiWrite(4'h0, 32'(32'h51 + i), resp);
    expectBeat("t4_new0", 32'h51, 1'b0);
    expectBeat("t4_new1", 32'h52, 1'b0);
    expectBeat("t4_new2", 32'h53, 1'b1);

    // 5: frame length change mid-frame, then a zero length
    axiWrite(4'h8, 32'd4, resp);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 12; i++) axiWrite(4'h0, 32'(32'h61 + i), resp);
    expectBeat("t5_old0", 32'h61, 1'b0);
    expectBeat("t5_old1", 32'h62, 1'b0);
    m_axis_tready = 1'b0;
    axiWrite(4'h8, 32'd8, resp);
    axiRead(4'h8, rd);  check("t5_len_rb", rd, 32'd8);
    expectBeat("t5_old2", 32'h63, 1'b0);
    expectBeat("t5_old3", 32'h64, 1'b1);
    for (int i = 0; i < 8; i++) expectBeat("t5_new", 32'(32'h65 + i), i == 7);
    axiWrite(4'h8, 32'd0, resp);
    axiRead(4'h8, rd);  check("t5_len0_rb", rd, 32'd1);
    m_axis_tready = 1'b0;
    axiWrite(4'h0, 32'h71, resp);
    axiWrite(4'h0, 32'h72, resp);
    expectBeat("t5_len1_a", 32'h71, 1'b1);
    expectBeat("t5_len1_b", 32'h72, 1'b1);

    // 6: reset in the middle of a burst
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) axiWrite(4'h0, 32'(32'h81 + i), resp);
    expectBeat("t6_first", 32'h81, 1'b1);
    tb_ARESETN = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_data", m_axis_tdata, 32'd0);
    m_axis_tready = 1'b0;
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    check("t6_valid_after", 32'(m_axis_tvalid), 32'd0);
    axiRead(4'hC, rd);  check("t6_status", rd, 32'h0001_0000);
    axiRead(4'h8, rd);  check("t6_framelen", rd, 32'd64);
    axiRead(4'h4, rd);  check("t6_ctrl", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
